uart_rx_fsm: RTL and testbench
==============================

Name: uart_rx_fsm

Overview:
- Frame controller for the UART receiver: detects the start bit, sequences start/data/parity/stop bit periods, and generates per-bit enables.
- Owns the oversampling edge counter and the bit counter. Downstream stages consume these counts: data sampler, deserializer, parity checker, start/stop checks.
- Consumes `sampled_bit` from the sampler and `par_error` from the parity checker, and issues a single-cycle `data_valid` per clean frame.

Parameters:
- DATA_WIDTH, 8, data bits per frame (LSB first); `bit_count` width fixed at 4.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- RX_IN  input  1  serial line, idle high
- PAR_EN  input  1  1 = frame carries a parity bit
- Prescale  input  6  oversampling ratio; legal values 8, 16, 32; static while a frame is in flight
- sampled_bit  input  1  majority-voted bit from sampler; valid when edge_count == Prescale/2+2
- par_error  input  1  parity checker result; held valid from the check point in PARITY onward
- edge_count  output  5  oversampling tick within current bit, 0..Prescale-1
- bit_count  output  4  bit index in frame: 0 = start, 1..8 = data, 9 = parity/stop, 10 = stop with parity
- dat_samp_en  output  1  sampler enable
- deser_en  output  1  one-cycle shift strobe to deserializer
- par_chk_en  output  1  parity checker enable
- strt_glitch  output  1  one-cycle pulse: start bit rejected
- stp_err  output  1  one-cycle pulse: stop bit sampled low
- data_valid  output  1  one-cycle pulse: frame accepted

Behaviour:
Reset and check point:
- rst low (async, any time, including mid-frame) forces state IDLE.
- All counters and outputs reset to 0.
- The deserializer contents are not the responsibility of this block.
- Check point CP = Prescale/2 + 2 (integer divide; 6/10/18 for 8/16/32).

States: IDLE, START, DATA, PARITY, STOP, DONE (registered state, separate next-state logic).

Counters:
- edge_count and bit_count are held at 0 in IDLE and DONE.
- In other states, edge_count increments each cycle.
- At edge_count == Prescale-1, edge_count wraps to 0 and bit_count increments.

IDLE:
- On RX_IN == 0, go to START.
- First START cycle has edge_count = 0, bit_count = 0.

START:
- dat_samp_en = 1.
- At edge CP, sampled_bit == 1 → strt_glitch pulses that cycle and the next state is IDLE.
- Otherwise, at edge Prescale-1 go to DATA.

DATA:
- dat_samp_en = 1.
- deser_en = 1 exactly on the cycle edge_count == CP (one strobe per data bit, 8 total).
- At edge Prescale-1 with bit_count == DATA_WIDTH, go to PARITY if PAR_EN, else STOP.

PARITY:
- dat_samp_en = 1 and par_chk_en = 1 for the whole state.
- At edge Prescale-1, latch par_error into an internal par_flag, then go to STOP.
- With PAR_EN = 0, par_flag is forced 0.

STOP:
- dat_samp_en = 1.
- At edge CP: sampled_bit == 0 → stp_err pulses that cycle and an internal stp_flag is set.
- The next state is DONE in both cases; the remainder of the stop bit is not waited for.

DONE (exactly 1 cycle):
- data_valid = !par_flag && !stp_flag.
- Flags clear on exit.
- RX_IN == 0 → go to START (back-to-back frame); else go to IDLE.

Output timing and error rules:
- All enables and pulses are registered-state decodes (Moore) or same-cycle decodes of edge_count; no combinational path from RX_IN to any output.
- Errors never stall the FSM.
- A parity or stop error suppresses data_valid only.

Test Plan:
1. Prescale=8, PAR_EN=0, byte 0x5A, clean stop. START entry = cycle 0.
   - deser_en at cycles 14, 22, …, 70.
   - stp_err never asserts.
   - data_valid high at cycle 79 only.
   - Then IDLE.
2. Prescale=8, PAR_EN=1, 0xA5, parity checker reports par_error=0.
   - par_chk_en high cycles 72–79.
   - data_valid at cycle 87.
   - Repeat with par_error=1: data_valid stays 0 and the FSM returns to IDLE.
3. Prescale=16, RX_IN low for only 3 cycles (glitch) → strt_glitch pulse at cycle 10, state IDLE at cycle 11, no deser_en.
4. Prescale=8, PAR_EN=0, stop bit driven low → stp_err pulse at cycle 78, data_valid 0 at cycle 79.
5. Prescale=32, two back-to-back frames 0x00 then 0xFF, second start bit immediately after DONE → two data_valid pulses, second START entered directly from DONE.
6. Prescale=8, assert rst at cycle 30 mid-DATA → all outputs 0 immediately (async). After release with RX_IN high, the FSM stays IDLE; the next frame decodes normally.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// uart_rx_fsm
//
// Frame controller for the UART receiver. It detects the start bit and
// walks through the start, data, optional parity and stop bit periods. It
// owns the oversampling edge counter and the bit counter that the sampler,
// deserializer, parity checker and start/stop checks consume. It raises a
// single-cycle data_valid for every frame that arrives without a parity or
// stop error.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   RX_IN        serial line, idle high
//   PAR_EN       1 = frame carries a parity bit
//   Prescale     oversampling ratio (8, 16 or 32), static during a frame
//   sampled_bit  majority-voted bit from the sampler, valid at the check point
//   par_error    parity checker result, valid from its check point in PARITY
//   edge_count   oversampling tick within the current bit
//   bit_count    bit index: 0 start, 1..8 data, 9 parity/stop, 10 stop
//   dat_samp_en  sampler enable
//   deser_en     one-cycle shift strobe to the deserializer
//   par_chk_en   parity checker enable
//   strt_glitch  one-cycle pulse, start bit rejected
//   stp_err      one-cycle pulse, stop bit sampled low
//   data_valid   one-cycle pulse, frame accepted
// ---------------------------------------------------------------------------
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] Prescale,
    input  logic       sampled_bit,
    input  logic       par_error,
    output logic [4:0] edge_count,
    output logic [3:0] bit_count,
    output logic       dat_samp_en,
    output logic       deser_en,
    output logic       par_chk_en,
    output logic       strt_glitch,
    output logic       stp_err,
    output logic       data_valid
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  edge_q, edge_d;
    logic [3:0]  bit_q, bit_d;
    logic        par_flag_q, par_flag_d;
    logic        stp_flag_q, stp_flag_d;

    logic [5:0]  lastEdgeVal;
    logic [5:0]  checkPointVal;
    logic        atLastEdge;
    logic        atCheckPoint;
    logic        counting;

    // The check point sits two ticks past the middle of the bit, where the
    // sampler has finished its majority vote.
    assign lastEdgeVal   = Prescale - 6'd1;
    assign checkPointVal = {1'b0, Prescale[5:1]} + 6'd2;
    assign atLastEdge    = ({1'b0, edge_q} == lastEdgeVal);
    assign atCheckPoint  = ({1'b0, edge_q} == checkPointVal);

    // State, counters and error flags; everything returns to zero/IDLE the
    // moment rst drops, even in the middle of a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            edge_q     <= '0;
            bit_q      <= '0;
            par_flag_q <= 1'b0;
            stp_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            par_flag_q <= par_flag_d;
            stp_flag_q <= stp_flag_d;
        end
    end

    // Next-state logic and flag capture. Errors never hold the FSM back;
    // they only mark the frame so DONE can withhold data_valid.
    always_comb begin
        state_d    = state_q;
        par_flag_d = par_flag_q;
        stp_flag_d = stp_flag_q;
        case (state_q)
            IDLE: begin
                par_flag_d = 1'b0;
                stp_flag_d = 1'b0;
                if (!RX_IN) begin
                    state_d = START;
                end
            end
            START: begin
                if (atCheckPoint && sampled_bit) begin
                    state_d = IDLE;
                end else if (atLastEdge) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (atLastEdge && (bit_q == 4'(DATA_WIDTH))) begin
                    state_d = PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (atLastEdge) begin
                    par_flag_d = par_error & PAR_EN;
                    state_d    = STOP;
                end
            end
            STOP: begin
                // The tail of the stop bit is not waited for, so a
                // back-to-back start bit can be caught straight from DONE.
                if (atCheckPoint) begin
                    if (!sampled_bit) begin
                        stp_flag_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                par_flag_d = 1'b0;
                stp_flag_d = 1'b0;
                state_d    = RX_IN ? IDLE : START;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Counters hold at zero whenever IDLE or DONE is involved on either side
    // of the clock edge, so every START begins at edge 0, bit 0.
    always_comb begin
        counting = (state_q != IDLE) && (state_q != DONE) &&
                   (state_d != IDLE) && (state_d != DONE);
        edge_d   = '0;
        bit_d    = '0;
        if (counting) begin
            if (atLastEdge) begin
                edge_d = '0;
                bit_d  = bit_q + 4'd1;
            end else begin
                edge_d = edge_q + 5'd1;
                bit_d  = bit_q;
            end
        end
    end

    // Output decodes from the registered state and the edge counter only;
    // RX_IN never reaches an output combinationally.
    always_comb begin
        edge_count  = edge_q;
        bit_count   = bit_q;
        dat_samp_en = (state_q == START) || (state_q == DATA) ||
                      (state_q == PARITY) || (state_q == STOP);
        deser_en    = (state_q == DATA) && atCheckPoint;
        par_chk_en  = (state_q == PARITY);
        strt_glitch = (state_q == START) && atCheckPoint && sampled_bit;
        stp_err     = (state_q == STOP) && atCheckPoint && !sampled_bit;
        data_valid  = (state_q == DONE) && !par_flag_q && !stp_flag_q;
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fsm
//
// Drives whole UART frames into uart_rx_fsm and compares every cycle's
// counters and enables against timing computed from the frame layout: a
// frame starting at relative cycle 0 spends Prescale cycles per bit, and
// each strobe lands at a fixed tick within a fixed bit.
// ---------------------------------------------------------------------------
module tb_uart_rx_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic       sampled_bit = 1'b1;
    logic       par_error = 1'b0;
    logic [4:0] edge_count;
    logic [3:0] bit_count;
    logic       dat_samp_en;
    logic       deser_en;
    logic       par_chk_en;
    logic       strt_glitch;
    logic       stp_err;
    logic       data_valid;

    int checks = 0;
    int errors = 0;
    int frameNo = 0;

    uart_rx_fsm #(.DATA_WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .RX_IN(RX_IN),
        .PAR_EN(PAR_EN),
        .Prescale(Prescale),
        .sampled_bit(sampled_bit),
        .par_error(par_error),
        .edge_count(edge_count),
        .bit_count(bit_count),
        .dat_samp_en(dat_samp_en),
        .deser_en(deser_en),
        .par_chk_en(par_chk_en),
        .strt_glitch(strt_glitch),
        .stp_err(stp_err),
        .data_valid(data_valid)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Compares counters and the six control outputs for the current cycle.
    // Control order: dat_samp_en, deser_en, par_chk_en, strt_glitch, stp_err, data_valid.
    task automatic checkCycle(input string tag, input logic [4:0] expEdge, input logic [3:0] expBit, input logic [5:0] expCtl);
        checkOutput({tag, ".cnt"}, {23'd0, edge_count, bit_count}, {23'd0, expEdge, expBit});
        checkOutput({tag, ".ctl"},
                    {26'd0, dat_samp_en, deser_en, par_chk_en, strt_glitch, stp_err, data_valid},
                    {26'd0, expCtl});
    endtask

    // Idle line: everything must read zero.
    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            RX_IN = 1'b1;
            sampled_bit = 1'b1;
            #1 checkCycle($sformatf("idle f%0d", frameNo), 5'd0, 4'd0, 6'd0);
        end
    endtask

    // Sends one frame. Relative cycle 0 is the first START cycle; the line
    // is pulled low one cycle earlier (in IDLE, or in the previous DONE when
    // fromDone is set). The sampler is modelled as returning the line value.
    task automatic applyStimulus(input int p, input bit parEn, input logic [7:0] data,
                                 input bit parErr, input bit stopBad, input bit glitch,
                                 input bit chainNext, input bit fromDone, input int abortAt);
        int cp;
        int stopIdx;
        int stopCp;
        int last;
        int b;
        int e;
        logic lineBit;
        logic [5:0] expCtl;
        bit aborted;
        cp = p / 2 + 2;
        stopIdx = parEn ? 10 : 9;
        stopCp = stopIdx * p + cp;
        last = glitch ? cp : stopCp + 1;
        aborted = 1'b0;
        frameNo++;
        if (!fromDone) begin
            @(negedge clk);
            Prescale = 6'(p);
            PAR_EN = parEn;
            par_error = parErr;
            RX_IN = 1'b0;
            sampled_bit = 1'b0;
            #1 checkCycle($sformatf("pre f%0d", frameNo), 5'd0, 4'd0, 6'd0);
        end
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            Prescale = 6'(p);
            PAR_EN = parEn;
            par_error = parErr;
            b = c / p;
            e = c % p;
            if (glitch) lineBit = (c < 2) ? 1'b0 : 1'b1;
            else if (c == last) lineBit = chainNext ? 1'b0 : 1'b1;
            else if (b == 0) lineBit = 1'b0;
            else if (b <= 8) lineBit = data[b-1];
            else if (parEn && b == 9) lineBit = ^data;
            else lineBit = !stopBad;
            RX_IN = lineBit;
            sampled_bit = lineBit;
            if (c == abortAt) begin
                rst = 1'b0;
                #1 checkCycle($sformatf("abort f%0d c%0d", frameNo, c), 5'd0, 4'd0, 6'd0);
                aborted = 1'b1;
                break;
            end
            #1;
            if (!glitch && c == last) begin
                expCtl = {5'b0, !(parEn && parErr) && !stopBad};
                checkCycle($sformatf("done f%0d c%0d", frameNo, c), 5'd0, 4'd0, expCtl);
            end else begin
                expCtl = {1'b1,
                          (b >= 1 && b <= 8 && e == cp),
                          (parEn && b == 9),
                          (glitch && c == cp),
                          (!glitch && stopBad && c == stopCp),
                          1'b0};
                checkCycle($sformatf("frame f%0d c%0d", frameNo, c), 5'(e), 4'(b), expCtl);
            end
        end
        if (aborted) begin
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                RX_IN = 1'b1;
                sampled_bit = 1'b1;
                #1 checkCycle($sformatf("inrst f%0d", frameNo), 5'd0, 4'd0, 6'd0);
            end
            @(negedge clk);
            RX_IN = 1'b1;
            sampled_bit = 1'b1;
            rst = 1'b1;
            #1 checkCycle($sformatf("release f%0d", frameNo), 5'd0, 4'd0, 6'd0);
        end
    endtask

    // Directed frames from the plan, then randomized frames.
    initial begin
        int p;
        bit chain;
        bit nextChain;
        bit parEn;
        bit parErr;
        bit stopBad;
        bit glitch;
        int abortAt;
        logic [7:0] data;

        #1 checkCycle("reset", 5'd0, 4'd0, 6'd0);
        @(negedge clk);
        rst = 1'b1;
        idleCycles(2);

        applyStimulus(8, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idleCycles(3);
        applyStimulus(8, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idleCycles(2);
        applyStimulus(8, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idleCycles(2);
        applyStimulus(16, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        idleCycles(3);
        applyStimulus(8, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        idleCycles(2);
        applyStimulus(32, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        applyStimulus(32, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idleCycles(2);
        applyStimulus(8, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30);
        idleCycles(4);
        applyStimulus(8, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idleCycles(2);

        chain = 1'b0;
        p = 8;
        for (int i = 0; i < 25; i++) begin
            if (!chain) begin
                case ($urandom_range(0, 2))
                    0: p = 8;
                    1: p = 16;
                    default: p = 32;
                endcase
            end
            parEn = 1'($urandom_range(0, 1));
            parErr = 1'($urandom_range(0, 1));
            data = 8'($urandom);
            stopBad = ($urandom_range(0, 3) == 0);
            glitch = ($urandom_range(0, 7) == 0);
            nextChain = !glitch && (i < 24) && ($urandom_range(0, 2) == 0);
            abortAt = -1;
            if (!glitch && !nextChain && $urandom_range(0, 9) == 0) begin
                abortAt = $urandom_range(1, 9 * p - 1);
            end
            applyStimulus(p, parEn, data, parErr, stopBad, glitch, nextChain, chain, abortAt);
            if (!nextChain) begin
                idleCycles($urandom_range(1, 3));
            end
            chain = nextChain;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
